// File: rtl/cfg_pkg.sv
// Shared types and defaults for the configuration sequencer.
package cfg_pkg;

    localparam int CFG_NUM_TILES = 16;
    localparam int CFG_ADDR_W    = 4;
    localparam int CFG_DATA_W    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } cfg_state_e;

    // One-hot tile strobe for a tile index.
    function automatic logic [CFG_NUM_TILES-1:0] onehot(input logic [CFG_ADDR_W-1:0] idx);
        logic [CFG_NUM_TILES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// Host command / word stream and fabric config strobe bundle.
interface config_sequencer_if #(
    parameter int NUM_TILES = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32
);
    logic                 start;
    logic [ADDR_W-1:0]    first_tile;
    logic [ADDR_W:0]      num_words;
    logic                 abort;
    logic [DATA_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    config_data;
    logic [NUM_TILES-1:0] config_en;
    logic                 busy;
    logic                 done;
    logic                 error;

    modport master (
        output start, first_tile, num_words, abort, in_data, in_valid,
        input  in_ready, config_data, config_en, busy, done, error
    );

    modport slave (
        input  start, first_tile, num_words, abort, in_data, in_valid,
        output in_ready, config_data, config_en, busy, done, error
    );
endinterface

// File: rtl/config_sequencer.sv
// Streams configuration words into consecutive switch-box tiles.
//
// state | meaning
// IDLE  | waiting for start; range-checks the request
// LOAD  | accepting words, one tile strobe per accepted word
// FLUSH | last strobe on the outputs, no more words accepted
// DONE  | one-cycle completion pulse
module config_sequencer
    import cfg_pkg::*;
#(
    parameter int NUM_TILES = CFG_NUM_TILES,
    parameter int ADDR_W    = CFG_ADDR_W,
    parameter int DATA_W    = CFG_DATA_W
) (
    input logic               clk,
    input logic               reset,
    config_sequencer_if.slave bus
);

    cfg_state_e           r_state;
    cfg_state_e           w_next_state;
    logic [ADDR_W-1:0]    r_ptr;
    logic [ADDR_W:0]      r_remaining;
    logic [DATA_W-1:0]    r_config_data;
    logic [NUM_TILES-1:0] r_config_en;
    logic                 r_error;

    logic [ADDR_W+1:0]    w_range_sum;
    logic                 w_range_bad;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_in_ready;
    logic                 w_busy;
    logic                 w_done;

    // Extra headroom bits so first_tile + num_words can never overflow.
    assign w_range_sum = {2'b00, bus.first_tile} + {1'b0, bus.num_words};
    assign w_range_bad = w_range_sum > (ADDR_W+2)'(NUM_TILES);
    assign w_beat      = (r_state == LOAD) && bus.in_valid && !bus.abort;
    assign w_last      = w_beat && (r_remaining == (ADDR_W+1)'(1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_range_bad) begin
                        w_next_state = IDLE;
                    end else if (bus.num_words == '0) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    w_next_state = IDLE;
                end else if (w_last) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH:   w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State-decoded outputs; in_ready deliberately ignores in_valid.
    always_comb begin
        w_in_ready = 1'b0;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            IDLE:    w_busy = 1'b0;
            LOAD:    begin w_in_ready = 1'b1; w_busy = 1'b1; end
            FLUSH:   w_busy = 1'b1;
            DONE:    begin w_busy = 1'b1; w_done = 1'b1; end
            default: w_busy = 1'b0;
        endcase
    end

    // Tile pointer, word counter, registered strobe/data and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr         <= '0;
            r_remaining   <= '0;
            r_config_data <= '0;
            r_config_en   <= '0;
            r_error       <= 1'b0;
        end else begin
            r_config_en <= '0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_ptr       <= bus.first_tile;
                        r_remaining <= bus.num_words;
                        r_error     <= w_range_bad;
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        r_error <= 1'b1;
                    end else if (w_beat) begin
                        r_config_data <= bus.in_data;
                        r_config_en   <= NUM_TILES'(onehot(CFG_ADDR_W'(r_ptr)));
                        r_ptr         <= r_ptr + ADDR_W'(1);
                        r_remaining   <= r_remaining - (ADDR_W+1)'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.error       = r_error;
    assign bus.config_data = r_config_data;
    assign bus.config_en   = r_config_en;

endmodule

// File: tb/tb_config_sequencer.sv
// Directed plus randomized load scenarios checked cycle by cycle against a tile/word model.
module tb_config_sequencer;

    localparam int NT = 16;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;

    config_sequencer_if #(.NUM_TILES(NT), .ADDR_W(AW), .DATA_W(DW)) bus ();

    config_sequencer #(.NUM_TILES(NT), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] last_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One load request. Model: tiles first..first+n-1 each receive the next
    // accepted word, strobe visible the cycle after acceptance.
    task automatic do_load(input int first, input int n, input int vprob, input int abort_beat,
                           input int pat_len, input logic [15:0] pat, input logic [DW-1:0] base);
        int tile;
        int left;
        int beats;
        int cyc;
        logic v;
        logic ab;
        logic [DW-1:0] d;

        bus.start      = 1'b1;
        bus.first_tile = AW'(first);
        bus.num_words  = (AW+1)'(n);
        tick;
        bus.start = 1'b0;

        if (first + n > NT) begin
            chk("range_err", bus.error, 1);
            chk("range_busy", bus.busy, 0);
            chk("range_en", bus.config_en, 0);
            tick;
            chk("range_nodone", bus.done, 0);
            chk("range_en2", bus.config_en, 0);
            chk("range_err_sticky", bus.error, 1);
            return;
        end
        chk("start_err_clr", bus.error, 0);

        if (n == 0) begin
            chk("zero_busy", bus.busy, 1);
            chk("zero_done", bus.done, 1);
            chk("zero_en", bus.config_en, 0);
            tick;
            chk("zero_busy_end", bus.busy, 0);
            chk("zero_done_end", bus.done, 0);
            chk("zero_en_end", bus.config_en, 0);
            return;
        end

        tile  = first;
        left  = n;
        beats = 0;
        cyc   = 0;
        while (left > 0) begin
            chk("ld_ready", bus.in_ready, 1);
            chk("ld_busy", bus.busy, 1);
            chk("ld_done", bus.done, 0);
            if (pat_len > 0) v = (cyc < pat_len) ? pat[cyc] : 1'b1;
            else             v = ($urandom_range(99) < vprob);
            d  = (base != '0) ? base + DW'(beats) : $urandom;
            ab = v && (beats == abort_beat);
            bus.in_valid   = v;
            bus.in_data    = d;
            bus.abort      = ab;
            bus.start      = 1'($urandom_range(1));
            bus.first_tile = AW'($urandom);
            bus.num_words  = (AW+1)'($urandom);
            tick;
            bus.in_valid = 1'b0;
            bus.abort    = 1'b0;
            bus.start    = 1'b0;
            cyc++;
            if (ab) begin
                chk("ab_en", bus.config_en, 0);
                chk("ab_data", bus.config_data, last_data);
                chk("ab_err", bus.error, 1);
                chk("ab_busy", bus.busy, 0);
                chk("ab_ready", bus.in_ready, 0);
                tick;
                chk("ab_nodone", bus.done, 0);
                chk("ab_en2", bus.config_en, 0);
                return;
            end
            if (v) begin
                chk("ld_en", bus.config_en, 64'(1) << tile);
                chk("ld_data", bus.config_data, d);
                last_data = d;
                tile++;
                left--;
                beats++;
            end else begin
                chk("gap_en", bus.config_en, 0);
                chk("gap_data", bus.config_data, last_data);
            end
            if (cyc > 300) begin
                chk("ld_timeout", 0, 1);
                return;
            end
        end

        chk("fl_ready", bus.in_ready, 0);
        chk("fl_busy", bus.busy, 1);
        chk("fl_done", bus.done, 0);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        chk("dn_done", bus.done, 1);
        chk("dn_en", bus.config_en, 0);
        chk("dn_busy", bus.busy, 1);
        chk("dn_err", bus.error, 0);
        tick;
        chk("id_done", bus.done, 0);
        chk("id_busy", bus.busy, 0);
        chk("id_ready", bus.in_ready, 0);
    endtask

    initial begin
        reset          = 1'b0;
        bus.start      = 1'b0;
        bus.first_tile = '0;
        bus.num_words  = '0;
        bus.abort      = 1'b0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        last_data      = '0;

        #12;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.error, 0);
        chk("rst_en", bus.config_en, 0);
        chk("rst_data", bus.config_data, 0);
        @(negedge clk);
        reset = 1'b1;
        tick;

        do_load(5, 3, 100, -1, 0, 16'h0, 32'hA0);
        do_load(14, 3, 100, -1, 0, 16'h0, 32'h0);
        do_load(7, 0, 100, -1, 0, 16'h0, 32'h0);
        do_load(0, 2, 0, -1, 4, 16'b1001, 32'h1000);
        do_load(2, 4, 100, 2, 0, 16'h0, 32'hB0);
        do_load(0, 16, 100, -1, 0, 16'h0, 32'h0);
        do_load(15, 1, 100, -1, 0, 16'h0, 32'h0);
        do_load(12, 5, 100, -1, 0, 16'h0, 32'h0);
        do_load(13, 3, 70, -1, 0, 16'h0, 32'h0);

        bus.start      = 1'b1;
        bus.first_tile = AW'(4);
        bus.num_words  = (AW+1)'(2);
        tick;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hC0;
        tick;
        bus.in_valid = 1'b0;
        chk("pre_rst_en", bus.config_en, 16'h0010);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_en", bus.config_en, 0);
        chk("arst_data", bus.config_data, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready", bus.in_ready, 0);
        last_data = '0;
        @(negedge clk);
        reset = 1'b1;
        tick;
        do_load(4, 2, 100, -1, 0, 16'h0, 32'hD0);

        for (int i = 0; i < 25; i++) begin
            int f;
            int n;
            int ab;
            f  = $urandom_range(15);
            n  = $urandom_range(16);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(15)) : -1;
            do_load(f, n, $urandom_range(100, 40), ab, 0, 16'h0, 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
